// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the seven-segment display controller:
//   register addresses, MODE bit positions, glyph codes, the converter
//   state type and the glyph -> active-high segment pattern function.
package seg7_pkg;

    localparam logic [1:0] ADDR_VALUE      = 2'd0;
    localparam logic [1:0] ADDR_MODE       = 2'd1;
    localparam logic [1:0] ADDR_BLINK_MASK = 2'd2;

    localparam int unsigned MODE_DEC_BIT = 0;  // 0 = hex, 1 = decimal
    localparam int unsigned MODE_LZB_BIT = 1;  // leading-zero blanking

    // Codes 0..15 coincide with the nibble value so a digit maps by cast.
    typedef enum logic [4:0] {
        DIGIT_0 = 5'd0,  DIGIT_1 = 5'd1,  DIGIT_2 = 5'd2,  DIGIT_3 = 5'd3,
        DIGIT_4 = 5'd4,  DIGIT_5 = 5'd5,  DIGIT_6 = 5'd6,  DIGIT_7 = 5'd7,
        DIGIT_8 = 5'd8,  DIGIT_9 = 5'd9,  DIGIT_A = 5'd10, DIGIT_B = 5'd11,
        DIGIT_C = 5'd12, DIGIT_D = 5'd13, DIGIT_E = 5'd14, DIGIT_F = 5'd15,
        DASH    = 5'd16,
        BLANK   = 5'd17
    } glyph_t;

    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_t;

    // Active-high pattern, bit0 = segment a .. bit6 = segment g.
    function automatic logic [6:0] glyph_to_seg(input glyph_t g);
        logic [6:0] seg;
        case (g)
            DIGIT_0: seg = 7'h3F;
            DIGIT_1: seg = 7'h06;
            DIGIT_2: seg = 7'h5B;
            DIGIT_3: seg = 7'h4F;
            DIGIT_4: seg = 7'h66;
            DIGIT_5: seg = 7'h6D;
            DIGIT_6: seg = 7'h7D;
            DIGIT_7: seg = 7'h07;
            DIGIT_8: seg = 7'h7F;
            DIGIT_9: seg = 7'h6F;
            DIGIT_A: seg = 7'h77;
            DIGIT_B: seg = 7'h7C;  // lowercase b
            DIGIT_C: seg = 7'h39;
            DIGIT_D: seg = 7'h5E;  // lowercase d
            DIGIT_E: seg = 7'h79;
            DIGIT_F: seg = 7'h71;
            DASH:    seg = 7'h40;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd
//   Iterative double-dabble binary to BCD converter, one shift-add-3 step
//   per clock, DATA_W steps per conversion. A start while running discards
//   the current conversion and restarts with the new input.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (aborts any conversion)
//   start_i  load bin_i and begin converting
//   bin_i    binary input, sampled with start_i
//   busy_o   conversion in progress
//   done_o   one-cycle pulse the cycle after the final step
//   bcd_o    NUM_DIGITS packed BCD digits (valid with done_o, held after)
//   ovf_o    a 1 was shifted out of the top BCD digit
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    ovf_o
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    conv_state_t       state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            CONV_IDLE: if (start_i) state_d = CONV_RUN;
            CONV_RUN: begin
                if (start_i)                    state_d = CONV_RUN;
                else if (cnt_q == CNT_W'(1))    state_d = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    // Add 3 to every digit >= 5 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_W);
            ovf_d = 1'b0;
        end else if (state_q == CONV_RUN) begin
            bin_d  = bin_q << 1;
            bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
            ovf_d  = ovf_q | bcd_adj[BCD_W-1];
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    // Outputs
    always_comb begin
        busy_o = (state_q == CONV_RUN);
        done_o = done_q;
        bcd_o  = bcd_q;
        ovf_o  = ovf_q;
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
//   N-digit seven-segment controller driven through a small write port.
//   Shows VALUE in hex or decimal, with optional leading-zero blanking and
//   (when built with SEG7_BLINK_EN) per-digit blinking.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   wr_en    register write strobe
//   wr_addr  0 = VALUE, 1 = MODE, 2 = BLINK_MASK, 3 = ignored
//   wr_data  write data
//   busy     decimal conversion in progress
//   seg_out  digit i at [7i+6:7i], bit0 = seg a .. bit6 = seg g (registered)
// Build option:
//   SEG7_BLINK_EN  enables BLINK_MASK and the blink counter
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [1:0]              wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    localparam int unsigned BCD_W    = 4 * NUM_DIGITS;
    localparam logic [6:0]  ZERO_SEG = ACTIVE_LOW ? ~glyph_to_seg(DIGIT_0)
                                                  : glyph_to_seg(DIGIT_0);

    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("BLINK_DIV must be at least 2");
    end

    logic [DATA_W-1:0]       value_q, value_d;
    logic [1:0]              mode_q, mode_d;
    logic                    conv_start, conv_done, conv_ovf;
    logic [BCD_W-1:0]        conv_bcd, bcd_buf_q, hex_src;
    logic                    ovf_buf_q;
    logic [NUM_DIGITS-1:0]   mask;
    logic                    blink_dark;
    glyph_t                  glyph [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] seg_d, seg_q;

    // Register writes; a conversion starts from the value being written so
    // busy rises the cycle right after the write.
    always_comb begin
        value_d = value_q;
        mode_d  = mode_q;
        if (wr_en && wr_addr == ADDR_VALUE) value_d = wr_data;
        if (wr_en && wr_addr == ADDR_MODE)  mode_d  = wr_data[1:0];
        conv_start = wr_en && (wr_addr == ADDR_VALUE || wr_addr == ADDR_MODE)
                     && mode_d[MODE_DEC_BIT];
    end

    seg7_bin2bcd #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_i   (clk),
        .rst_i   (reset),
        .start_i (conv_start),
        .bin_i   (value_d),
        .busy_o  (busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    // Bits of VALUE beyond the displayable nibbles are ignored
    if (DATA_W >= BCD_W) begin : g_hex_trunc
        assign hex_src = value_q[BCD_W-1:0];
    end else begin : g_hex_ext
        assign hex_src = {{(BCD_W - DATA_W){1'b0}}, value_q};
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;

    always_comb begin
        mask_d      = mask_q;
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        phase_d     = phase_q;
        if (wr_en && wr_addr == ADDR_BLINK_MASK) mask_d = wr_data[NUM_DIGITS-1:0];
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign mask       = mask_q;
    assign blink_dark = phase_q;
`else
    assign mask       = '0;
    assign blink_dark = 1'b0;
`endif

    // Glyph selection, walking from the top digit down so "seen" marks
    // whether any nonzero digit sits at or above the current position.
    always_comb begin
        logic [3:0]  nib;
        logic        seen;
        int unsigned idx;
        glyph   = '{default: BLANK};
        seen    = 1'b0;
        nib     = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx  = NUM_DIGITS - 1 - k;
            nib  = mode_q[MODE_DEC_BIT] ? bcd_buf_q[4*idx +: 4] : hex_src[4*idx +: 4];
            seen = seen | (nib != 4'd0);
            if (mode_q[MODE_DEC_BIT] && ovf_buf_q)
                glyph[idx] = DASH;
            else if (mode_q[MODE_LZB_BIT] && !seen && idx != 0)
                glyph[idx] = BLANK;
            else
                glyph[idx] = glyph_t'({1'b0, nib});
            if (blink_dark && mask[idx])
                glyph[idx] = BLANK;
        end
    end

    always_comb begin
        seg_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            seg_d[7*i +: 7] = ACTIVE_LOW ? ~glyph_to_seg(glyph[i]) : glyph_to_seg(glyph[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q   <= '0;
            mode_q    <= '0;
            bcd_buf_q <= '0;
            ovf_buf_q <= 1'b0;
            seg_q     <= {NUM_DIGITS{ZERO_SEG}};
        end else begin
            value_q <= value_d;
            mode_q  <= mode_d;
            if (conv_done) begin
                bcd_buf_q <= conv_bcd;
                ovf_buf_q <= conv_ovf;
            end
            seg_q <= seg_d;
        end
    end

    assign seg_out = seg_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
module tb_seg7_display_ctrl;

    localparam int ND  = 8;
    localparam int DW  = 32;
    localparam int DIV = 4;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          wr_en   = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          busy;
    logic [55:0]   seg_out;

    seg7_display_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .BLINK_DIV  (DIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .seg_out (seg_out)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Active-high glyphs: 0-9, A-F, dash (16), blank (17)
    logic [6:0] GLYPH [0:17] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                                 7'h40, 7'h00};
    longint P10 [0:8] = '{1, 10, 100, 1000, 10000, 100000, 1000000, 10000000, 100000000};

    // Reference model state
    logic [31:0] m_value;
    logic [1:0]  m_mode;
    logic [7:0]  m_mask;
    bit          m_busy, m_done, m_ovf, m_phase;
    int          m_left, m_bcnt;
    longint      m_conv, m_buf;
    logic [55:0] m_seg;

    function automatic logic [55:0] render();
        int d [8];
        int top;
        logic [55:0] r;
        for (int i = 0; i < ND; i++) begin
            if (m_mode[0]) d[i] = m_ovf ? 16 : int'((m_buf / P10[i]) % 10);
            else           d[i] = int'((m_value >> (4 * i)) & 32'hF);
        end
        if (m_mode[1] && !(m_mode[0] && m_ovf)) begin
            top = 0;
            for (int i = 0; i < ND; i++) if (d[i] != 0) top = i;
            for (int i = 0; i < ND; i++) if (i > top) d[i] = 17;
        end
        if (BLINK && m_phase)
            for (int i = 0; i < ND; i++) if (m_mask[i]) d[i] = 17;
        for (int i = 0; i < ND; i++) r[7*i +: 7] = ~GLYPH[d[i]];
        return r;
    endfunction

    // Apply one clock edge to the model, using the inputs present at that edge
    task automatic model_edge();
        logic [55:0] nxt;
        nxt = render();
        if (reset) begin
            m_value = 0; m_mode = 0; m_mask = 0;
            m_busy = 0; m_done = 0; m_left = 0;
            m_buf = 0; m_ovf = 0; m_conv = 0;
            m_bcnt = 0; m_phase = 0;
            m_seg = {8{7'h40}};
        end else begin
            m_seg = nxt;
            if (m_done) begin
                m_buf  = m_conv;
                m_ovf  = (m_conv >= P10[8]);
                m_done = 0;
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (wr_en) begin
                case (wr_addr)
                    2'd0: m_value = wr_data;
                    2'd1: m_mode  = wr_data[1:0];
                    2'd2: if (BLINK) m_mask = wr_data[7:0];
                    default: ;
                endcase
                if (wr_addr <= 2'd1 && m_mode[0]) begin
                    m_busy = 1; m_left = DW; m_conv = m_value; m_done = 0;
                end
            end
            if (m_bcnt == DIV - 1) begin
                m_bcnt  = 0;
                m_phase = !m_phase;
            end else begin
                m_bcnt++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_eq("busy", busy, m_busy);
        check_eq("seg", seg_out, m_seg);
        wr_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        if (k >= 100) check_eq("idle_timeout", busy, 0);
    endtask

    initial begin
        int cnt, dark, vis;
        logic [31:0] d;

        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_seg", seg_out, {8{7'h40}});

        // Reset in the middle of a conversion
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd999);
        repeat (5) step();
        check_eq("conv_running", busy, 1);
        pulse_reset();
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_seg", seg_out, {8{7'h40}});

        // Hex
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h0000BEEF);
        step();
        check_eq("hex_beef", seg_out, {{4{7'h40}}, 7'h03, 7'h06, 7'h06, 7'h0E});

        // Decimal 12345 and busy length
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd12345);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
        check_eq("busy_len", cnt, 32);
        step(); step();
        check_eq("dec_12345", seg_out, {{3{7'h40}}, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        wr(2'd1, 32'd3);
        step();
        check_eq("lzb_top", seg_out[55:35], {3{7'h7F}});
        check_eq("lzb_low", seg_out[34:0], {7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        wait_idle();

        // Decimal overflow
        wr(2'd0, 32'd100_000_000);
        wait_idle();
        step(); step();
        check_eq("dec_ovf", seg_out, {8{7'h3F}});

        // Restart while busy: the abandoned 5 never appears
        pulse_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd5);
        repeat (10) begin
            step();
            check_eq("no5", seg_out[6:0] == 7'h12, 0);
        end
        wr(2'd0, 32'd7);
        repeat (34) begin
            check_eq("no5", seg_out[6:0] == 7'h12, 0);
            step();
        end
        check_eq("dec_7", seg_out[6:0], 7'h78);

        // Blink mask on digit 0
        pulse_reset();
        wr(2'd2, 32'h0000_0001);
        dark = 0; vis = 0;
        repeat (16) begin
            step();
            check_eq("blink_others", seg_out[55:7], {7{7'h40}});
            if (seg_out[6:0] == 7'h7F) dark++;
            else if (seg_out[6:0] == 7'h40) vis++;
        end
        if (BLINK) begin
            check_eq("blink_dark_cnt", dark, 8);
            check_eq("blink_vis_cnt", vis, 8);
        end else begin
            check_eq("no_blink", dark, 0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: d = $urandom;
                    1: d = $urandom_range(0, 9999);
                    2: d = 32'd99_999_990 + $urandom_range(0, 20);
                    default: d = $urandom & 32'h000F_F0FF;
                endcase
                wr(2'($urandom_range(0, 3)), d);
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
